drop_controller: RTL and testbench
==================================

Name: drop_controller

Overview:
- Consumes the current-player colour from the turn tracker and produces that tracker's advance pulse.
- Accepts a column request and checks column occupancy.
- Animates the piece falling row by row for the display path, then writes the piece into board memory.
- Issues exactly one turn-advance pulse per successful move. Sits between player input/debounce logic and the board RAM/VGA drawer.

Parameters:
- COLS, 7, number of board columns.
- ROWS, 6, number of board rows; row 0 is the top row.
- FALL_TICKS, 2, clock cycles the falling piece spends displayed on each row (must be at least 1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- turn  input  2  current colour from turn tracker: 01 or 10 valid; 00 and 11 invalid.
- col_sel  input  3  requested column, 0..COLS-1.
- drop_req  input  1  single-cycle move request.
- new_game  input  1  synchronous clear of board occupancy.
- busy  output  1  high whenever state is not IDLE.
- anim_valid  output  1  falling-piece overlay valid.
- anim_row  output  3  overlay row of the falling piece.
- anim_col  output  3  overlay column of the falling piece.
- wr_en  output  1  board RAM write strobe, one cycle.
- wr_row  output  3  board RAM write row.
- wr_col  output  3  board RAM write column.
- wr_colour  output  2  colour written; equals turn latched at accept.
- turn_enable  output  1  one-cycle advance pulse to turn tracker.
- drop_ack  output  1  one-cycle pulse, move completed.
- drop_reject  output  1  one-cycle pulse, request refused.
- board_full  output  1  every column holds ROWS pieces.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - State returns to IDLE.
  - All per-column heights and the tick counter clear to 0.
  - Every output is 0; wr_colour is 00.
- States are IDLE, FALL, WRITE, ADVANCE.
- IDLE, on drop_req=1:
  - Accept when col_sel<COLS, height[col_sel]<ROWS and turn is 01 or 10.
  - On accept, latch col=col_sel, colour=turn and target=ROWS-1-height[col]; set anim_row=0 and go to FALL.
  - Any other request produces a drop_reject pulse on the next cycle and the state stays IDLE.
- FALL:
  - anim_valid=1 and anim_col=col.
  - The tick counter counts 0..FALL_TICKS-1. At terminal count with anim_row<target, anim_row increments and the counter resets.
  - At terminal count with anim_row==target, go to WRITE.
  - Dwell is (target+1)*FALL_TICKS cycles.
- WRITE (1 cycle):
  - wr_en=1, wr_row=target, wr_col=col, wr_colour=colour.
  - anim_valid=0.
  - height[col] increments at the end of the cycle.
- ADVANCE (1 cycle):
  - turn_enable=1 and drop_ack=1, then return to IDLE.
  - board_full is recomputed from the heights and is valid from this cycle onward.
- Latency from the accept edge to the turn_enable cycle is (target+1)*FALL_TICKS+1 cycles.
- drop_req while busy is ignored: no queueing and no reject pulse.
- drop_req while board_full produces a reject.
- new_game:
  - In any state, forces IDLE on the next edge and clears all heights and board_full.
  - If asserted during FALL or WRITE, no wr_en, turn_enable or drop_ack is issued for the aborted move.
  - new_game takes priority over a simultaneous drop_req.
- turn is sampled only at accept; later changes to turn do not alter wr_colour.
- A height never exceeds ROWS, so there is no wrap-around.
- wr_row, wr_col and wr_colour hold their last values outside WRITE; consumers qualify them with wr_en.

Decomposition:
- Shared package connect4_pkg holds:
  - COLS and ROWS defaults.
  - Colour constants PIECE_NONE=00, PIECE_A=01, PIECE_B=10.
  - The controller state encoding.
- Sub-module fall_ticker (parameter FALL_TICKS) provides the dwell counter with a terminal-count output; it is cleared on state entry.
- Height storage stays in drop_controller: a COLS x 3-bit register array.

Test Plan:
- After reset, turn=01, col_sel=3, drop_req pulse:
  - anim_row steps 0..5, 2 cycles each (12 cycles).
  - wr_en with row 5, col 3, colour 01.
  - Next cycle: turn_enable=1 and drop_ack=1.
- Second drop into col 3 with turn=10:
  - FALL lasts 10 cycles.
  - wr_en with row 4, colour 10.
  - Exactly one turn_enable.
- Six drops into col 0, then a seventh request on col 0:
  - drop_reject pulses.
  - No wr_en and no turn_enable.
  - busy stays 0.
- col_sel=7, or turn=00: drop_reject pulses and state does not change.
- Aborts mid-FALL:
  - drop_req during FALL is ignored.
  - new_game mid-FALL returns to IDLE with no wr_en or turn_enable, and the next drop into that column writes row 5.
  - reset=0 asserted mid-FALL with the clock stopped forces all outputs to 0 immediately.
- Board fill:
  - Fill all 42 cells alternating turn; board_full rises in the 42nd ADVANCE cycle.
  - A subsequent drop_req is rejected.
  - new_game clears board_full.

Source files
------------

// File: rtl/connect4_pkg.sv
// ---------------------------------------------------------------------------
// connect4_pkg
// Shared constants for the Connect-4 datapath: board geometry defaults,
// piece colour codes and the drop controller state encoding.
// ---------------------------------------------------------------------------
package connect4_pkg;

    // Default board geometry; row 0 is the top row.
    localparam int C4_COLS = 7;
    localparam int C4_ROWS = 6;

    // Piece colour codes as stored in board RAM.
    localparam logic [1:0] PIECE_NONE = 2'b00;
    localparam logic [1:0] PIECE_A    = 2'b01;
    localparam logic [1:0] PIECE_B    = 2'b10;

    // Drop controller state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FALL    = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_ADVANCE = 2'd3;

    // True for a colour that belongs to a player (01 or 10).
    function automatic logic valid_piece(input logic [1:0] c);
        return (c == PIECE_A) || (c == PIECE_B);
    endfunction

endpackage

// File: rtl/fall_ticker.sv
// ---------------------------------------------------------------------------
// fall_ticker
// Dwell counter for the falling-piece animation. Counts 0..FALL_TICKS-1
// while en is high and wraps at terminal count; held at 0 while en is low,
// so each entry into the falling state starts from a fresh count.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   en     count enable (high while the piece is falling)
//   tc     terminal count, high on the last cycle of a row's dwell
// ---------------------------------------------------------------------------
module fall_ticker #(
    parameter int FALL_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc
);

    localparam int CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(FALL_TICKS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/drop_controller.sv
// ---------------------------------------------------------------------------
// drop_controller
// Accepts a column request from the player input path, checks the column
// has room, animates the piece falling row by row for the VGA overlay,
// writes the piece into board RAM and pulses the turn tracker once per
// completed move.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   turn[1:0]             current player colour (01/10 valid)
//   col_sel[2:0]          requested column
//   drop_req              single-cycle move request
//   new_game              synchronous clear of board occupancy
//   busy                  controller is not idle
//   anim_valid/row/col    falling-piece overlay
//   wr_en/row/col/colour  board RAM write port (fields hold outside wr_en)
//   turn_enable           one-cycle advance pulse to the turn tracker
//   drop_ack              one-cycle pulse, move completed
//   drop_reject           one-cycle pulse, request refused
//   board_full            every column holds ROWS pieces
// ---------------------------------------------------------------------------
module drop_controller
    import connect4_pkg::*;
#(
    parameter int COLS       = C4_COLS,
    parameter int ROWS       = C4_ROWS,
    parameter int FALL_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] turn,
    input  logic [2:0] col_sel,
    input  logic       drop_req,
    input  logic       new_game,
    output logic       busy,
    output logic       anim_valid,
    output logic [2:0] anim_row,
    output logic [2:0] anim_col,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_colour,
    output logic       turn_enable,
    output logic       drop_ack,
    output logic       drop_reject,
    output logic       board_full
);

    logic [1:0] state;
    logic [2:0] heights [COLS];
    logic [2:0] col_q;
    logic [2:0] target_q;
    logic [2:0] row_q;
    logic [1:0] colour_q;
    logic [2:0] sel_height;
    logic       accept;
    logic       fall_active;
    logic       tick_tc;
    logic       full;

    // Height of the requested column; an out-of-range column reads as full
    // so it is refused by the same room check.
    always_comb begin
        // NOTE: assign a default before any conditional update so the block
        // stays purely combinational and no latch is inferred.
        sel_height = 3'(ROWS);
        for (int c = 0; c < COLS; c++) begin
            if (col_sel == 3'(c)) sel_height = heights[c];
        end
    end

    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (heights[c] != 3'(ROWS)) full = 1'b0;
        end
    end

    assign accept = (sel_height < 3'(ROWS)) && valid_piece(turn);

    assign fall_active = (state == ST_FALL);

    fall_ticker #(.FALL_TICKS(FALL_TICKS)) u_ticker (
        .clk   (clk),
        .reset (reset),
        .en    (fall_active),
        .tc    (tick_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            col_q       <= '0;
            target_q    <= '0;
            row_q       <= '0;
            colour_q    <= PIECE_NONE;
            wr_row      <= '0;
            wr_col      <= '0;
            wr_colour   <= PIECE_NONE;
            drop_reject <= 1'b0;
            // NOTE: the height array is only COLS small registers and its
            // contents decide legality of every move, so it is reset too.
            for (int c = 0; c < COLS; c++) heights[c] <= '0;
        end else begin
            drop_reject <= 1'b0;
            if (new_game) begin
                // Aborts any move in flight before its write or advance.
                state <= ST_IDLE;
                for (int c = 0; c < COLS; c++) heights[c] <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (drop_req) begin
                            if (accept) begin
                                col_q    <= col_sel;
                                colour_q <= turn;
                                target_q <= 3'(ROWS - 1) - sel_height;
                                row_q    <= '0;
                                state    <= ST_FALL;
                            end else begin
                                drop_reject <= 1'b1;
                            end
                        end
                    end
                    ST_FALL: begin
                        if (tick_tc) begin
                            if (row_q < target_q) begin
                                row_q <= row_q + 3'd1;
                            end else begin
                                // Load the write fields so they are stable
                                // for the whole WRITE cycle and hold after.
                                wr_row    <= target_q;
                                wr_col    <= col_q;
                                wr_colour <= colour_q;
                                state     <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        for (int c = 0; c < COLS; c++) begin
                            if (col_q == 3'(c)) heights[c] <= heights[c] + 3'd1;
                        end
                        state <= ST_ADVANCE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign anim_valid  = fall_active;
    assign anim_row    = row_q;
    assign anim_col    = col_q;
    assign wr_en       = (state == ST_WRITE);
    assign turn_enable = (state == ST_ADVANCE);
    assign drop_ack    = (state == ST_ADVANCE);
    assign board_full  = full;

endmodule

// File: tb/tb_drop_controller.sv
// ---------------------------------------------------------------------------
// tb_drop_controller
// Self-checking bench for drop_controller: a cycle-count reference model of
// each move compared against the DUT on every falling clock edge, plus
// directed scenarios with hand-computed expectations and a random phase.
// ---------------------------------------------------------------------------
module tb_drop_controller;

    localparam int COLS = 7;
    localparam int ROWS = 6;
    localparam int F    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] turn = 2'b00;
    logic [2:0] col_sel = 3'd0;
    logic       drop_req = 1'b0;
    logic       new_game = 1'b0;
    logic       busy, anim_valid, wr_en, turn_enable, drop_ack, drop_reject, board_full;
    logic [2:0] anim_row, anim_col, wr_row, wr_col;
    logic [1:0] wr_colour;

    bit clk_run = 1'b1;
    bit chk_en  = 1'b0;
    int n_pass  = 0;
    int n_total = 0;

    drop_controller #(.COLS(COLS), .ROWS(ROWS), .FALL_TICKS(F)) dut (
        .clk         (clk),
        .reset       (reset),
        .turn        (turn),
        .col_sel     (col_sel),
        .drop_req    (drop_req),
        .new_game    (new_game),
        .busy        (busy),
        .anim_valid  (anim_valid),
        .anim_row    (anim_row),
        .anim_col    (anim_col),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_colour   (wr_colour),
        .turn_enable (turn_enable),
        .drop_ack    (drop_ack),
        .drop_reject (drop_reject),
        .board_full  (board_full)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // A move is described by the number of cycles since its accept edge:
    // k < (target+1)*F falling on row k/F, k == dwell is the write cycle,
    // k == dwell+1 the advance cycle.
    int         m_h [COLS];
    bit         m_busy = 0;
    int         m_k = 0, m_col = 0, m_target = 0;
    logic [1:0] m_colour = 2'b00;
    bit         m_rej = 0;
    int         m_wr_row = 0, m_wr_col = 0;
    logic [1:0] m_wr_colour = 2'b00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_k = 0; m_col = 0; m_target = 0; m_colour = 0; m_rej = 0;
            m_wr_row = 0; m_wr_col = 0; m_wr_colour = 0;
            for (int c = 0; c < COLS; c++) m_h[c] = 0;
        end else begin
            m_rej = 0;
            if (new_game) begin
                m_busy = 0;
                for (int c = 0; c < COLS; c++) m_h[c] = 0;
            end else if (m_busy) begin
                if (m_k == (m_target + 1) * F + 1) begin
                    m_busy = 0;
                end else begin
                    m_k++;
                    if (m_k == (m_target + 1) * F) begin
                        m_wr_row = m_target; m_wr_col = m_col; m_wr_colour = m_colour;
                    end
                    if (m_k == (m_target + 1) * F + 1) m_h[m_col]++;
                end
            end else if (drop_req) begin
                if (int'(col_sel) < COLS && m_h[col_sel] < ROWS && (turn == 2'b01 || turn == 2'b10)) begin
                    m_busy = 1; m_k = 0; m_col = int'(col_sel); m_colour = turn;
                    m_target = ROWS - 1 - m_h[col_sel];
                end else begin
                    m_rej = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int e_d;
    bit e_av, e_full;
    always @(negedge clk) begin
        if (chk_en) begin
            e_d = (m_target + 1) * F;
            e_av = m_busy && (m_k < e_d);
            e_full = 1;
            for (int c = 0; c < COLS; c++) if (m_h[c] != ROWS) e_full = 0;
            check("busy", busy, m_busy);
            check("anim_valid", anim_valid, e_av);
            if (e_av) begin
                check("anim_row", anim_row, m_k / F);
                check("anim_col", anim_col, m_col);
            end
            check("wr_en", wr_en, m_busy && m_k == e_d);
            check("turn_enable", turn_enable, m_busy && m_k == e_d + 1);
            check("drop_ack", drop_ack, m_busy && m_k == e_d + 1);
            check("drop_reject", drop_reject, m_rej);
            check("board_full", board_full, e_full);
            check("wr_row", wr_row, m_wr_row);
            check("wr_col", wr_col, m_wr_col);
            check("wr_colour", wr_colour, m_wr_colour);
        end
    end

    // ---------------- directed helpers ----------------
    int         r_fall, r_wr, r_te, r_rej, r_row, r_col, r_lat;
    logic [1:0] r_colour;
    logic       r_bf;
    bit         r_busy;

    task automatic issue(input int c, input logic [1:0] t);
        @(negedge clk);
        col_sel = 3'(c); turn = t; drop_req = 1'b1;
        @(negedge clk);
        drop_req = 1'b0;
        turn = 2'($urandom);
    endtask

    task automatic wait_idle();
        bit done = 0;
        r_fall = 0; r_wr = 0; r_te = 0; r_rej = 0; r_row = -1; r_col = -1;
        r_colour = 2'b00; r_lat = -1; r_bf = 1'b0; r_busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) r_busy = 1;
            if (anim_valid) r_fall++;
            if (wr_en) begin
                r_wr++; r_row = int'(wr_row); r_col = int'(wr_col); r_colour = wr_colour;
            end
            if (turn_enable) begin
                r_te++; r_lat = i; r_bf = board_full;
            end
            if (drop_reject) r_rej++;
            if (!busy) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        check("idle_timeout", done, 1);
    endtask

    task automatic do_drop(input int c, input logic [1:0] t);
        issue(c, t);
        wait_idle();
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_anim_valid", anim_valid, 0);
        check("rst_anim_row", anim_row, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_colour", wr_colour, 0);
        check("rst_turn_enable", turn_enable, 0);
        check("rst_drop_reject", drop_reject, 0);
        check("rst_board_full", board_full, 0);
        reset = 1'b1;
        chk_en = 1'b1;

        // First drop: six rows of dwell, lands on the bottom row.
        do_drop(3, 2'b01);
        check("d1_fall_cycles", r_fall, 12);
        check("d1_wr_count", r_wr, 1);
        check("d1_wr_row", r_row, 5);
        check("d1_wr_col", r_col, 3);
        check("d1_wr_colour", r_colour, 2'b01);
        check("d1_te_count", r_te, 1);
        check("d1_latency", r_lat, 13);

        // Stacked drop lands one row higher.
        do_drop(3, 2'b10);
        check("d2_fall_cycles", r_fall, 10);
        check("d2_wr_row", r_row, 4);
        check("d2_wr_colour", r_colour, 2'b10);
        check("d2_te_count", r_te, 1);
        check("d2_latency", r_lat, 11);

        // Fill column 0, then request it once more.
        pulse_new_game();
        for (int i = 0; i < ROWS; i++) do_drop(0, (i % 2 == 0) ? 2'b01 : 2'b10);
        check("col0_top_row", r_row, 0);
        do_drop(0, 2'b01);
        check("full_col_reject", r_rej, 1);
        check("full_col_wr", r_wr, 0);
        check("full_col_te", r_te, 0);
        check("full_col_busy", r_busy, 0);

        // Bad column and bad colour.
        do_drop(7, 2'b01);
        check("bad_col_reject", r_rej, 1);
        do_drop(2, 2'b00);
        check("bad_turn_reject", r_rej, 1);
        do_drop(2, 2'b11);
        check("bad_turn11_reject", r_rej, 1);

        // Request while falling is ignored.
        issue(1, 2'b10);
        repeat (3) @(negedge clk);
        col_sel = 3'd5; turn = 2'b01; drop_req = 1'b1;
        @(negedge clk);
        drop_req = 1'b0;
        wait_idle();
        check("busy_req_te", r_te, 1);
        check("busy_req_wr_col", r_col, 1);
        check("busy_req_reject", r_rej, 0);

        // new_game mid-fall aborts the move.
        issue(2, 2'b01);
        repeat (3) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        wait_idle();
        check("abort_wr", r_wr, 0);
        check("abort_te", r_te, 0);
        do_drop(2, 2'b10);
        check("after_abort_row", r_row, 5);

        // Asynchronous reset mid-fall with the clock stopped.
        issue(4, 2'b01);
        repeat (3) @(negedge clk);
        clk_run = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_anim_valid", anim_valid, 0);
        check("areset_anim_row", anim_row, 0);
        check("areset_anim_col", anim_col, 0);
        check("areset_wr_en", wr_en, 0);
        check("areset_wr_row", wr_row, 0);
        check("areset_wr_colour", wr_colour, 0);
        check("areset_te", turn_enable, 0);
        #2 reset = 1'b1;
        #2 clk_run = 1'b1;

        // Fill the whole board.
        pulse_new_game();
        for (int i = 0; i < ROWS * COLS; i++) begin
            do_drop(i % COLS, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("fill_te", r_te, 1);
            check("fill_bf_at_advance", r_bf, (i == ROWS * COLS - 1) ? 1 : 0);
        end
        do_drop(3, 2'b01);
        check("full_board_reject", r_rej, 1);
        check("full_board_flag", board_full, 1);
        pulse_new_game();
        check("new_game_clears_full", board_full, 0);

        // Random traffic checked by the per-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            drop_req = ($urandom_range(3) == 0);
            col_sel  = 3'($urandom_range(7));
            turn     = ($urandom_range(7) == 0) ? 2'($urandom) : (($urandom_range(1) == 0) ? 2'b01 : 2'b10);
            new_game = ($urandom_range(299) == 0);
        end
        @(negedge clk);
        drop_req = 1'b0;
        new_game = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
